ext_io_bank: RTL

EXT_IO_BANK -- requirements
Module: ext_io_bank

---
 rtl/ext_io_bank.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ext_io_bank.sv
// ext_io_bank: memory-mapped general-purpose I/O bank.
// Provides an output register with set/clear aliases, per-bit direction
// control, a synchronised input view, and edge-triggered interrupt status
// with write-one-to-clear semantics.
module ext_io_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_9000,
  parameter int          IO_W        = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [31:0]     addr_i,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [31:0]     data_i,
  output logic [31:0]     data_o,
  output logic            rvalid_o,
  input  logic [IO_W-1:0] ext_data_i,
  output logic [IO_W-1:0] ext_data_o,
  output logic [IO_W-1:0] ext_oe_o,
  output logic            irq_o
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_OUT_SET = 3'd1,
    REG_OUT_CLR = 3'd2,
    REG_IN      = 3'd3,
    REG_DIR     = 3'd4,
    REG_IE_RISE = 3'd5,
    REG_IE_FALL = 3'd6,
    REG_STATUS  = 3'd7
  } regSel_e;

  // Events are ignored until the synchroniser and the history register both
  // hold real pad samples, so a pad that is already high at reset release
  // does not look like a rising edge.
  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

  logic [IO_W-1:0] out_q, out_d;
  logic [IO_W-1:0] dir_q, dir_d;
  logic [IO_W-1:0] ieRise_q, ieRise_d;
  logic [IO_W-1:0] ieFall_q, ieFall_d;
  logic [IO_W-1:0] status_q, status_d;
  logic [IO_W-1:0] prev_q;
  logic [IO_W-1:0] evt_q, evt_d;
  logic [IO_W-1:0] sync_q [SYNC_STAGES];
  logic [2:0]      fill_q;
  logic [31:0]     data_q;
  logic            rvalid_q;

  logic [29:0]     wordOff;
  logic            hit;
  regSel_e         regSel;
  logic [IO_W-1:0] wrData;
  logic [IO_W-1:0] syncOut;
  logic [IO_W-1:0] rise;
  logic [IO_W-1:0] fall;
  logic            primed;
  logic [31:0]     rdWord;
  logic            unusedBits;

  // Word offset from the base; addresses below the base wrap to large
  // values and therefore fall outside the eight-word window.
  assign wordOff    = addr_i[31:2] - BASE_ADDR[31:2];
  assign hit        = (wordOff < 30'd8);
  assign regSel     = regSel_e'(wordOff[2:0]);
  assign wrData     = data_i[IO_W-1:0];
  assign syncOut    = sync_q[SYNC_STAGES-1];
  assign rise       = syncOut & ~prev_q;
  assign fall       = ~syncOut & prev_q;
  assign primed     = (fill_q == FILL_DONE);
  assign unusedBits = ^{addr_i[1:0], data_i};

  // Qualify pad edges with direction and enables; registered before STATUS.
  always_comb begin
    evt_d = '0;
    if (primed) begin
      evt_d = ~dir_q & ((rise & ieRise_q) | (fall & ieFall_q));
    end
  end

  // Next-state for the software-visible registers; a set event beats a W1C.
  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    ieRise_d = ieRise_q;
    ieFall_d = ieFall_q;
    status_d = status_q;
    if (we_i && hit) begin
      case (regSel)
        REG_OUT:     out_d    = wrData;
        REG_OUT_SET: out_d    = out_q | wrData;
        REG_OUT_CLR: out_d    = out_q & ~wrData;
        REG_DIR:     dir_d    = wrData;
        REG_IE_RISE: ieRise_d = wrData;
        REG_IE_FALL: ieFall_d = wrData;
        REG_STATUS:  status_d = status_q & ~wrData;
        default:     ;
      endcase
    end
    status_d = status_d | (evt_q & ~dir_q);
  end

  // Read mux built from current register values, so a same-cycle write
  // returns the pre-write contents.
  always_comb begin
    rdWord = '0;
    if (hit) begin
      case (regSel)
        REG_OUT, REG_OUT_SET, REG_OUT_CLR: rdWord = 32'(out_q);
        REG_IN:      rdWord = 32'(syncOut);
        REG_DIR:     rdWord = 32'(dir_q);
        REG_IE_RISE: rdWord = 32'(ieRise_q);
        REG_IE_FALL: rdWord = 32'(ieFall_q);
        REG_STATUS:  rdWord = 32'(status_q);
        default:     rdWord = '0;
      endcase
    end
  end

  // Input synchroniser chain for the asynchronous pads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= ext_data_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Register file, edge history and startup fill counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_q    <= '0;
      dir_q    <= '0;
      ieRise_q <= '0;
      ieFall_q <= '0;
      status_q <= '0;
      prev_q   <= '0;
      evt_q    <= '0;
      fill_q   <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      ieRise_q <= ieRise_d;
      ieFall_q <= ieFall_d;
      status_q <= status_d;
      prev_q   <= syncOut;
      evt_q    <= evt_d;
      if (!primed) begin
        fill_q <= fill_q + 3'd1;
      end
    end
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rvalid_q <= 1'b0;
      data_q   <= '0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) begin
        data_q <= rdWord;
      end
    end
  end

  assign data_o     = data_q;
  assign rvalid_o   = rvalid_q;
  assign ext_data_o = out_q;
  assign ext_oe_o   = dir_q;
  assign irq_o      = |status_q;

endmodule
